// File: rtl/shift_alu_pkg.sv
// rtl/shift_alu_pkg.sv - shared opcodes, widths and command record for the shift ALU path
package shift_alu_pkg;

    localparam int REGISTER_WIDTH = 32;
    localparam int CMD_TAG_W      = 4;

    localparam logic [2:0] SHLEFTLOG = 3'b000;
    localparam logic [2:0] SHLEFTART = 3'b001;
    localparam logic [2:0] SHRGHTLOG = 3'b010;
    localparam logic [2:0] SHRGHTART = 3'b011;

    typedef struct packed {
        logic [2:0]                op;
        logic [4:0]                shift;
        logic [REGISTER_WIDTH-1:0] data;
        logic [CMD_TAG_W-1:0]      tag;
    } shift_cmd_t;

    // Only the four shift encodings are understood by the ALU; 1xx is reserved.
    function automatic logic is_legal_op(input logic [2:0] op);
        return (op[2] == 1'b0);
    endfunction

endpackage

// File: rtl/shift_cmd_fifo.sv
// rtl/shift_cmd_fifo.sv - power-of-two command FIFO with occupancy count
module shift_cmd_fifo
    import shift_alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       push,
    input  shift_cmd_t push_cmd,
    input  logic       pop,
    output shift_cmd_t head_cmd,
    output logic       full,
    output logic       empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    shift_cmd_t       mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign head_cmd = mem[rd_ptr];

    // Storage needs no reset: entries are only read while count says they are valid.
    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_cmd;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/shift_issue_queue.sv
// rtl/shift_issue_queue.sv - buffered issue of shift commands to the ALU with a tagged result slot; option SHIFT_ISSUE_ILLEGAL_CHECK_EN
module shift_issue_queue
    import shift_alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = CMD_TAG_W
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [2:0]                cmd_op,
    input  logic [4:0]                cmd_shift,
    input  logic [REGISTER_WIDTH-1:0] cmd_data,
    input  logic [TAG_W-1:0]          cmd_tag,
    output logic                      alu_enable,
    output logic [2:0]                alu_op,
    output logic [4:0]                alu_shift,
    output logic [REGISTER_WIDTH-1:0] alu_in,
    input  logic [REGISTER_WIDTH:0]   alu_out,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [REGISTER_WIDTH:0]   res_data,
`ifdef SHIFT_ISSUE_ILLEGAL_CHECK_EN
    output logic                      res_err,
`endif
    output logic [TAG_W-1:0]          res_tag
);

    shift_cmd_t push_cmd;
    shift_cmd_t head;
    logic       full;
    logic       empty;
    logic       issue;

    assign push_cmd.op    = cmd_op;
    assign push_cmd.shift = cmd_shift;
    assign push_cmd.data  = cmd_data;
    assign push_cmd.tag   = CMD_TAG_W'(cmd_tag);

    shift_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (cmd_valid),
        .push_cmd (push_cmd),
        .pop      (issue),
        .head_cmd (head),
        .full     (full),
        .empty    (empty)
    );

    assign cmd_ready = !full;
    // A held result blocks issue because the ALU output is the result storage.
    assign issue     = !empty && (!res_valid || res_ready);
    assign alu_op    = head.op;
    assign alu_shift = head.shift;
    assign alu_in    = head.data;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            res_valid <= 1'b0;
            res_tag   <= '0;
        end else if (issue) begin
            res_valid <= 1'b1;
            res_tag   <= TAG_W'(head.tag);
        end else if (res_ready) begin
            res_valid <= 1'b0;
        end
    end

`ifdef SHIFT_ISSUE_ILLEGAL_CHECK_EN
    assign alu_enable = issue && is_legal_op(head.op);
    assign res_data   = res_err ? '0 : alu_out;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            res_err <= 1'b0;
        end else if (issue) begin
            res_err <= !is_legal_op(head.op);
        end
    end
`else
    assign alu_enable = issue;
    assign res_data   = alu_out;
`endif

endmodule
